// File: rtl/swervolf_uart_pkg.sv
// Shared types and helpers for the SweRVolf UART receive monitor.
// Parity modes, receiver FSM states and the baud divider calculation.
package swervolf_uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_STOP2,
        ST_BREAK
    } rx_state_e;

    function automatic int uart_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/swervolf_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count.
// A write into a full FIFO is accepted only when a pop happens in the same cycle.
module swervolf_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             rd_fire, wr_fire;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign rd_fire = rd_en_i & ~empty_o;
    assign wr_fire = wr_en_i & (~full_o | rd_fire);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (wr_fire) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_fire) rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({wr_fire, rd_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem_q[wr_ptr_q] <= wr_data_i;
    end

    // Storage is not reset, so an empty FIFO presents zero.
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o   = count_q;

endmodule

// File: rtl/swervolf_uart_monitor.sv
// UART receiver for the SweRVolf console line with a receive FIFO.
// Configurable frame format; sticky framing, parity and overflow flags.
module swervolf_uart_monitor #(
    parameter int CLK_FREQ_HZ = 25_000_000,
    parameter int BAUD        = 115200,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_rx,
    output logic [7:0]                    o_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic                          o_frame_err,
    output logic                          o_parity_err,
    output logic                          o_overflow,
    input  logic                          i_clr_err
);
    import swervolf_uart_pkg::*;

    localparam int      DIV      = uart_div(CLK_FREQ_HZ, BAUD);
    localparam int      CW       = $clog2(DIV);
    localparam parity_e PAR_MODE = parity_e'(PARITY);
    localparam logic [CW-1:0] FULL = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);

    if (DIV < 4 || DATA_BITS < 5 || DATA_BITS > 8 ||
        PARITY < 0 || PARITY > 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2) || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_err
        $error("swervolf_uart_monitor: parameter out of range");
    end

    logic                 rx_meta_q, rx_sync_q;
    rx_state_e            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 pbad_q, pbad_d;
    logic                 fe_q, fe_d, pe_q, pe_d, ov_q, ov_d;
    logic                 tick, par_bad, push;
    logic                 set_fe, set_pe, set_ov;
    logic                 fifo_full;
    logic [DATA_BITS-1:0] fifo_dout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= i_rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    assign tick    = (cnt_q == '0);
    assign par_bad = (PAR_MODE == PAR_ODD) ? ~(^{data_q, rx_sync_q})
                                           :  (^{data_q, rx_sync_q});

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        data_d  = data_q;
        pbad_d  = pbad_q;
        push    = 1'b0;
        set_fe  = 1'b0;
        set_pe  = 1'b0;
        if (!tick) cnt_d = cnt_q - 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                // Only reachable with the line high, so low here is a falling edge.
                if (!rx_sync_q) begin
                    state_d = ST_START;
                    cnt_d   = HALF;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (rx_sync_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                        cnt_d   = FULL;
                        bit_d   = '0;
                        pbad_d  = 1'b0;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    data_d = {rx_sync_q, data_q[DATA_BITS-1:1]};
                    cnt_d  = FULL;
                    bit_d  = bit_q + 1'b1;
                    if (bit_q == 3'(DATA_BITS - 1)) begin
                        state_d = (PAR_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    pbad_d  = par_bad;
                    set_pe  = par_bad;
                    cnt_d   = FULL;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (!rx_sync_q) begin
                        set_fe  = 1'b1;
                        state_d = ST_BREAK;
                    end else if (STOP_BITS == 2) begin
                        cnt_d   = FULL;
                        state_d = ST_STOP2;
                    end else begin
                        push    = ~pbad_q;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_STOP2: begin
                if (tick) begin
                    if (!rx_sync_q) begin
                        set_fe  = 1'b1;
                        state_d = ST_BREAK;
                    end else begin
                        push    = ~pbad_q;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_BREAK: begin
                if (rx_sync_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A full FIFO always has a valid head, so only i_ready decides a pop.
    assign set_ov = push & fifo_full & ~i_ready;

    always_comb begin
        fe_d = set_fe | (fe_q & ~i_clr_err);
        pe_d = set_pe | (pe_q & ~i_clr_err);
        ov_d = set_ov | (ov_q & ~i_clr_err);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            pbad_q  <= 1'b0;
            fe_q    <= 1'b0;
            pe_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            pbad_q  <= pbad_d;
            fe_q    <= fe_d;
            pe_q    <= pe_d;
            ov_q    <= ov_d;
        end
    end

    swervolf_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (push),
        .wr_data_i (data_q),
        .rd_en_i   (i_ready),
        .rd_data_o (fifo_dout),
        .empty_o   (),
        .full_o    (fifo_full),
        .count_o   (o_count)
    );

    assign o_data       = 8'(fifo_dout);
    assign o_valid      = (o_count != '0);
    assign o_frame_err  = fe_q;
    assign o_parity_err = pe_q;
    assign o_overflow   = ov_q;

endmodule

// File: tb/tb_swervolf_uart_monitor.sv
// Directed bench: instance A is 8N1 depth 4, instance B is 7E2 depth 4.
// Both run at 25 MHz / 115200 baud (217 clocks per bit).
module tb_swervolf_uart_monitor;

    localparam int DIV = 217;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       rx_a = 1'b1, rdy_a = 1'b0, clr_a = 1'b0;
    logic [7:0] data_a;
    logic       valid_a, fe_a, pe_a, ov_a;
    logic [2:0] count_a;

    logic       rx_b = 1'b1, rdy_b = 1'b0, clr_b = 1'b0;
    logic [7:0] data_b;
    logic       valid_b, fe_b, pe_b, ov_b;
    logic [2:0] count_b;

    int checks = 0;
    int failures = 0;

    always #20 clk = ~clk;

    swervolf_uart_monitor #(
        .CLK_FREQ_HZ (25_000_000),
        .BAUD        (115200),
        .DATA_BITS   (8),
        .PARITY      (0),
        .STOP_BITS   (1),
        .FIFO_DEPTH  (4)
    ) dut_a (
        .clk          (clk),
        .rst          (rst),
        .i_rx         (rx_a),
        .o_data       (data_a),
        .o_valid      (valid_a),
        .i_ready      (rdy_a),
        .o_count      (count_a),
        .o_frame_err  (fe_a),
        .o_parity_err (pe_a),
        .o_overflow   (ov_a),
        .i_clr_err    (clr_a)
    );

    swervolf_uart_monitor #(
        .CLK_FREQ_HZ (25_000_000),
        .BAUD        (115200),
        .DATA_BITS   (7),
        .PARITY      (2),
        .STOP_BITS   (2),
        .FIFO_DEPTH  (4)
    ) dut_b (
        .clk          (clk),
        .rst          (rst),
        .i_rx         (rx_b),
        .o_data       (data_b),
        .o_valid      (valid_b),
        .i_ready      (rdy_b),
        .o_count      (count_b),
        .o_frame_err  (fe_b),
        .o_parity_err (pe_b),
        .o_overflow   (ov_b),
        .i_clr_err    (clr_b)
    );

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input int inst, input logic v);
        if (inst == 0) rx_a = v;
        else rx_b = v;
        wait_cyc(DIV);
    endtask

    task automatic send_frame(input int inst, input logic [7:0] d,
                              input int nbits, input int par,
                              input bit flip, input int nstop,
                              input logic stop_v);
        logic p;
        p = 1'b0;
        for (int i = 0; i < nbits; i++) p = p ^ d[i];
        if (par == 1) p = ~p;
        if (flip) p = ~p;
        drive_bit(inst, 1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(inst, d[i]);
        if (par != 0) drive_bit(inst, p);
        for (int i = 0; i < nstop; i++) drive_bit(inst, stop_v);
    endtask

    task automatic pop_a();
        rdy_a = 1'b1;
        wait_cyc(1);
        rdy_a = 1'b0;
    endtask

    task automatic pop_b();
        rdy_b = 1'b1;
        wait_cyc(1);
        rdy_b = 1'b0;
    endtask

    task automatic clear_a();
        clr_a = 1'b1;
        wait_cyc(1);
        clr_a = 1'b0;
    endtask

    task automatic clear_b();
        clr_b = 1'b1;
        wait_cyc(1);
        clr_b = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_cyc(3);
        checks++;
        if ({valid_a, data_a, count_a} !== 12'h000) begin
            failures++;
            $display("FAIL reset_a_stream: got v=%b d=%h c=%0d want 0/00/0",
                     valid_a, data_a, count_a);
        end
        checks++;
        if ({fe_a, pe_a, ov_a, fe_b, pe_b, ov_b} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b want 000000",
                     {fe_a, pe_a, ov_a, fe_b, pe_b, ov_b});
        end
        checks++;
        if ({valid_b, data_b, count_b} !== 12'h000) begin
            failures++;
            $display("FAIL reset_b_stream: got v=%b d=%h c=%0d want 0/00/0",
                     valid_b, data_b, count_b);
        end
        rst = 1'b0;
        wait_cyc(2);
    endtask

    task automatic test_basic();
        int n;
        n = 0;
        fork
            send_frame(0, 8'h55, 8, 0, 1'b0, 1, 1'b1);
            begin
                while (!valid_a && n < 2400) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
            end
        join
        checks++;
        if (!valid_a || n < 1953 || n > 2173) begin
            failures++;
            $display("FAIL basic_latency: got %0d cycles want 1953..2173", n);
        end
        send_frame(0, 8'hA3, 8, 0, 1'b0, 1, 1'b1);
        checks++;
        if (count_a !== 3'd2 || data_a !== 8'h55) begin
            failures++;
            $display("FAIL basic_first: got c=%0d d=%h want 2/55",
                     count_a, data_a);
        end
        pop_a();
        checks++;
        if (count_a !== 3'd1 || data_a !== 8'hA3) begin
            failures++;
            $display("FAIL basic_second: got c=%0d d=%h want 1/a3",
                     count_a, data_a);
        end
        pop_a();
        checks++;
        if (valid_a !== 1'b0 || count_a !== 3'd0 || data_a !== 8'h00) begin
            failures++;
            $display("FAIL basic_empty: got v=%b c=%0d d=%h want 0/0/00",
                     valid_a, count_a, data_a);
        end
        checks++;
        if ({fe_a, pe_a, ov_a} !== 3'b000) begin
            failures++;
            $display("FAIL basic_flags: got %b want 000", {fe_a, pe_a, ov_a});
        end
    endtask

    task automatic test_parity();
        send_frame(1, 8'h41, 7, 2, 1'b0, 2, 1'b1);
        checks++;
        if (count_b !== 3'd1 || data_b !== 8'h41 || pe_b !== 1'b0) begin
            failures++;
            $display("FAIL parity_good: got c=%0d d=%h pe=%b want 1/41/0",
                     count_b, data_b, pe_b);
        end
        send_frame(1, 8'h41, 7, 2, 1'b1, 2, 1'b1);
        checks++;
        if (count_b !== 3'd1 || pe_b !== 1'b1 || fe_b !== 1'b0) begin
            failures++;
            $display("FAIL parity_bad: got c=%0d pe=%b fe=%b want 1/1/0",
                     count_b, pe_b, fe_b);
        end
        clear_b();
        checks++;
        if (pe_b !== 1'b0) begin
            failures++;
            $display("FAIL parity_clear: got %b want 0", pe_b);
        end
        pop_b();
        checks++;
        if (valid_b !== 1'b0) begin
            failures++;
            $display("FAIL parity_drain: got v=%b want 0", valid_b);
        end
    endtask

    task automatic test_frame();
        send_frame(0, 8'h7E, 8, 0, 1'b0, 1, 1'b0);
        wait_cyc(1000);
        checks++;
        if (fe_a !== 1'b1 || count_a !== 3'd0) begin
            failures++;
            $display("FAIL frame_err: got fe=%b c=%0d want 1/0", fe_a, count_a);
        end
        rx_a = 1'b1;
        wait_cyc(2 * DIV);
        clear_a();
        checks++;
        if (fe_a !== 1'b0) begin
            failures++;
            $display("FAIL frame_clear: got %b want 0", fe_a);
        end
        send_frame(0, 8'h12, 8, 0, 1'b0, 1, 1'b1);
        checks++;
        if (count_a !== 3'd1 || data_a !== 8'h12 || fe_a !== 1'b0) begin
            failures++;
            $display("FAIL frame_recover: got c=%0d d=%h fe=%b want 1/12/0",
                     count_a, data_a, fe_a);
        end
        pop_a();
    endtask

    task automatic test_glitch();
        rx_a = 1'b0;
        wait_cyc(DIV / 4);
        rx_a = 1'b1;
        wait_cyc(12 * DIV);
        checks++;
        if (valid_a !== 1'b0 || {fe_a, pe_a, ov_a} !== 3'b000) begin
            failures++;
            $display("FAIL glitch: got v=%b flags=%b want 0/000",
                     valid_a, {fe_a, pe_a, ov_a});
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp;
        for (int i = 1; i <= 4; i++) begin
            send_frame(0, 8'(i), 8, 0, 1'b0, 1, 1'b1);
        end
        checks++;
        if (count_a !== 3'd4 || ov_a !== 1'b0) begin
            failures++;
            $display("FAIL ovf_full: got c=%0d ov=%b want 4/0", count_a, ov_a);
        end
        send_frame(0, 8'h05, 8, 0, 1'b0, 1, 1'b1);
        checks++;
        if (count_a !== 3'd4 || ov_a !== 1'b1) begin
            failures++;
            $display("FAIL ovf_drop: got c=%0d ov=%b want 4/1", count_a, ov_a);
        end
        for (int i = 1; i <= 4; i++) begin
            exp = 8'(i);
            checks++;
            if (data_a !== exp) begin
                failures++;
                $display("FAIL ovf_drain%0d: got %h want %h", i, data_a, exp);
            end
            pop_a();
        end
        checks++;
        if (count_a !== 3'd0 || ov_a !== 1'b1) begin
            failures++;
            $display("FAIL ovf_empty: got c=%0d ov=%b want 0/1", count_a, ov_a);
        end
        clear_a();
        checks++;
        if (ov_a !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear: got %b want 0", ov_a);
        end
    endtask

    task automatic test_reset_mid();
        fork
            send_frame(0, 8'h5A, 8, 0, 1'b0, 1, 1'b1);
            send_frame(1, 8'h41, 7, 2, 1'b1, 2, 1'b1);
        join
        checks++;
        if (count_a !== 3'd1 || pe_b !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre: got c=%0d pe_b=%b want 1/1",
                     count_a, pe_b);
        end
        drive_bit(0, 1'b0);
        for (int i = 0; i < 3; i++) drive_bit(0, 1'b1);
        wait_cyc(DIV / 2);
        rst = 1'b1;
        wait_cyc(3);
        rx_a = 1'b1;
        rst = 1'b0;
        wait_cyc(1);
        checks++;
        if ({valid_a, data_a, count_a} !== 12'h000 ||
            {fe_a, pe_a, ov_a, pe_b, valid_b} !== 5'b0) begin
            failures++;
            $display("FAIL rstmid_state: got v=%b d=%h c=%0d flags=%b want 0",
                     valid_a, data_a, count_a, {fe_a, pe_a, ov_a, pe_b, valid_b});
        end
        wait_cyc(2 * DIV);
        send_frame(0, 8'h3C, 8, 0, 1'b0, 1, 1'b1);
        checks++;
        if (count_a !== 3'd1 || data_a !== 8'h3C || fe_a !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_next: got c=%0d d=%h fe=%b want 1/3c/0",
                     count_a, data_a, fe_a);
        end
        pop_a();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_frame();
        test_glitch();
        test_overflow();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
